// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and an occupancy counter.
// Overflow and underflow requests are dropped silently; reset clears control state but not storage.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] buf_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  buf_empty,
  output logic                  buf_full,
  output logic [BUF_WIDTH:0]    fifo_counter
);

  localparam int DEPTH = 1 << BUF_WIDTH;
  localparam logic [BUF_WIDTH:0] DEPTH_CNT = {1'b1, {BUF_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [BUF_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [BUF_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BUF_WIDTH:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0] buf_out_q, buf_out_d;

  logic wr_accept;
  logic rd_accept;

  // Flags derive from the counter alone, so a full FIFO refuses writes even
  // when a read is accepted on the same edge.
  assign buf_empty    = (count_q == '0);
  assign buf_full     = (count_q == DEPTH_CNT);
  assign fifo_counter = count_q;
  assign buf_out      = buf_out_q;

  assign wr_accept = wr_en && !buf_full;
  assign rd_accept = rd_en && !buf_empty;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    buf_out_d = buf_out_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + BUF_WIDTH'(1);
    end

    if (rd_accept) begin
      rd_ptr_d  = rd_ptr_q + BUF_WIDTH'(1);
      buf_out_d = mem_q[rd_ptr_q];
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      buf_out_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      buf_out_q <= buf_out_d;
    end
  end

  // NOTE: the storage array has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) begin
      mem_q[wr_ptr_q] <= buf_in;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Scenario bench for sync_fifo: a queue scoreboard models accepted writes and
// reads; each test task compares the DUT against the model inline.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int BW    = 3;
  localparam int DEPTH = 1 << BW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] buf_in = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] buf_out;
  logic          buf_empty;
  logic          buf_full;
  logic [BW:0]   fifo_counter;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb [$];
  int            model_count = 0;
  logic [DW-1:0] exp_out = '0;

  logic [DW-1:0] drain_exp [8] = '{8'd2, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70};

  sync_fifo #(.DATA_WIDTH(DW), .BUF_WIDTH(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .buf_in       (buf_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .buf_out      (buf_out),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .fifo_counter (fifo_counter)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock with the given requests; the model decides acceptance from its
  // own pre-edge occupancy.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    bit wa, ra;
    wa = w && (model_count < DEPTH);
    ra = r && (model_count > 0);
    wr_en  = w;
    buf_in = d;
    rd_en  = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (ra) exp_out = sb.pop_front();
    if (wa) sb.push_back(d);
    model_count = model_count + int'(wa) - int'(ra);
  endtask

  // Reset with both requests asserted to exercise reset priority.
  task automatic do_reset();
    rst    = 1'b1;
    wr_en  = 1'b1;
    rd_en  = 1'b1;
    buf_in = 8'hEE;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    sb.delete();
    model_count = 0;
    exp_out = '0;
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    checks++;
    if (fifo_counter !== 4'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", fifo_counter);
    end
    checks++;
    if (buf_empty !== 1'b1 || buf_full !== 1'b0) begin
      errors++; $display("FAIL reset_flags: empty=%b full=%b want 1/0", buf_empty, buf_full);
    end
    checks++;
    if (buf_out !== 8'd0) begin
      errors++; $display("FAIL reset_out: got %0d want 0", buf_out);
    end
  endtask

  task automatic test_write_read_same();
    cycle(1'b1, 8'd1, 1'b0);
    checks++;
    if (fifo_counter !== 4'd1 || buf_empty !== 1'b0) begin
      errors++; $display("FAIL first_write: count=%0d empty=%b want 1/0", fifo_counter, buf_empty);
    end
    cycle(1'b1, 8'd2, 1'b1);
    checks++;
    if (buf_out !== 8'd1 || buf_out !== exp_out) begin
      errors++; $display("FAIL wr_rd_same_out: got %0d want 1", buf_out);
    end
    checks++;
    if (fifo_counter !== 4'd1) begin
      errors++; $display("FAIL wr_rd_same_count: got %0d want 1", fifo_counter);
    end
  endtask

  task automatic test_fill_full();
    for (int i = 1; i <= 7; i++) cycle(1'b1, 8'(i * 10), 1'b0);
    checks++;
    if (fifo_counter !== 4'd8 || buf_full !== 1'b1) begin
      errors++; $display("FAIL fill_full: count=%0d full=%b want 8/1", fifo_counter, buf_full);
    end
    cycle(1'b1, 8'd80, 1'b0);
    checks++;
    if (fifo_counter !== 4'd8 || buf_full !== 1'b1) begin
      errors++; $display("FAIL overflow_ignored: count=%0d full=%b want 8/1", fifo_counter, buf_full);
    end
  endtask

  task automatic test_drain();
    logic [DW-1:0] last;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'd0, 1'b1);
      checks++;
      if (buf_out !== exp_out || buf_out !== drain_exp[i]) begin
        errors++; $display("FAIL drain_%0d: got %0d want %0d", i, buf_out, drain_exp[i]);
      end
    end
    checks++;
    if (buf_empty !== 1'b1 || fifo_counter !== 4'd0) begin
      errors++; $display("FAIL drain_empty: empty=%b count=%0d want 1/0", buf_empty, fifo_counter);
    end
    last = buf_out;
    cycle(1'b0, 8'd0, 1'b1);
    checks++;
    if (buf_out !== 8'd70 || buf_out !== last) begin
      errors++; $display("FAIL underflow_hold: got %0d want 70", buf_out);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(140 + i), 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 8'(200 + i), 1'b1);
      checks++;
      if (buf_out !== exp_out) begin
        errors++; $display("FAIL wrap_rd_%0d: got %0d want %0d", i, buf_out, exp_out);
      end
    end
    checks++;
    if (fifo_counter !== 4'd4) begin
      errors++; $display("FAIL wrap_count: got %0d want 4", fifo_counter);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'd0, 1'b1);
      checks++;
      if (buf_out !== exp_out) begin
        errors++; $display("FAIL wrap_drain_%0d: got %0d want %0d", i, buf_out, exp_out);
      end
    end
  endtask

  task automatic test_simul_full_empty();
    logic [DW-1:0] held;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom_range(0, 127)), 1'b0);
    cycle(1'b1, 8'hAA, 1'b1);
    checks++;
    if (fifo_counter !== 4'd7 || buf_full !== 1'b0) begin
      errors++; $display("FAIL full_wr_rd_count: count=%0d full=%b want 7/0", fifo_counter, buf_full);
    end
    checks++;
    if (buf_out !== exp_out) begin
      errors++; $display("FAIL full_wr_rd_out: got %0d want %0d", buf_out, exp_out);
    end
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 8'd0, 1'b1);
      checks++;
      if (buf_out !== exp_out || buf_out === 8'hAA) begin
        errors++; $display("FAIL full_drain_%0d: got %0d want %0d", i, buf_out, exp_out);
      end
    end
    held = buf_out;
    cycle(1'b1, 8'h55, 1'b1);
    checks++;
    if (fifo_counter !== 4'd1 || buf_out !== held) begin
      errors++; $display("FAIL empty_wr_rd: count=%0d out=%0d want 1/%0d", fifo_counter, buf_out, held);
    end
    cycle(1'b0, 8'd0, 1'b1);
    checks++;
    if (buf_out !== 8'h55 || buf_out !== exp_out) begin
      errors++; $display("FAIL empty_wr_kept: got %0d want 85", buf_out);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(30 + i), 1'b0);
    cycle(1'b0, 8'd0, 1'b1);
    cycle(1'b1, 8'd99, 1'b0);
    checks++;
    if (fifo_counter !== 4'd5) begin
      errors++; $display("FAIL pre_reset_count: got %0d want 5", fifo_counter);
    end
    do_reset();
    checks++;
    if (fifo_counter !== 4'd0 || buf_empty !== 1'b1 || buf_out !== 8'd0) begin
      errors++; $display("FAIL mid_reset: count=%0d empty=%b out=%0d want 0/1/0",
                         fifo_counter, buf_empty, buf_out);
    end
    cycle(1'b1, 8'd5, 1'b0);
    cycle(1'b0, 8'd0, 1'b1);
    checks++;
    if (buf_out !== 8'd5 || buf_out !== exp_out || buf_empty !== 1'b1) begin
      errors++; $display("FAIL post_reset_rd: out=%0d empty=%b want 5/1", buf_out, buf_empty);
    end
  endtask

  initial begin
    test_reset();
    test_write_read_same();
    test_fill_full();
    test_drain();
    test_wrap();
    test_simul_full_empty();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
